seg_display_mux: RTL and testbench
==================================

Name: seg_display_mux

Overview:
- Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display.
- Holds a double-buffered digit frame and scans one digit per refresh slot.
- Drives active-low segment, decimal-point and anode lines, with decimal/hex decode, per-digit blanking, leading-zero blanking and anti-ghosting dead time.
- Sits between datapath result registers and the board display pins.

Parameters:
- NUM_DIGITS, 4, digits scanned; legal range 1..8.
- CLK_DIV, 100000, clk cycles per digit slot; minimum 2.
- BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off; must be < CLK_DIV.
- HEX_MODE, 1, 1 = codes 10..15 show A,b,C,d,E,F; 0 = codes 10..15 show blank.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- digits_in  input  4*NUM_DIGITS  digit codes; nibble i drives digit i, digit 0 least significant.
- dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = on.
- blank_in  input  NUM_DIGITS  force digit fully dark (segments and dp), 1 = blank.
- lzb_en  input  1  enable leading-zero blanking; sampled with load.
- load  input  1  single-cycle strobe that captures digits_in, dp_in, blank_in and lzb_en.
- seg  output  7  active-low segments, bit order GFEDCBA (bit 6 = G, middle; A = top, then clockwise).
- dp  output  1  active-low decimal point.
- an  output  NUM_DIGITS  active-low anode enables.
- frame_done  output  1  one-cycle pulse when the last digit slot ends.

Behaviour:
- Reset (async assert, sync release):
  - seg = 7'b1111111, dp = 1, an = all ones, frame_done = 0.
  - Prescaler = 0, digit index = 0.
  - Active and pending frames = all zero (digits 0, dp off, blank off, lzb off); pending_valid = 0.
  - Reset mid-scan aborts the slot immediately; outputs go dark on assertion, not at the next edge.
- Prescaler:
  - Counts 0..CLK_DIV-1, then wraps.
  - tick = (prescaler == CLK_DIV-1).
  - On tick the index increments and wraps NUM_DIGITS-1 -> 0.
  - wrap = tick && index == NUM_DIGITS-1.
- Double buffer:
  - load captures all inputs into pending and sets pending_valid.
  - A load while pending_valid = 1 overwrites pending (latest wins).
  - On wrap with pending_valid = 1: active <= pending, pending_valid <= 0.
  - load and wrap in the same cycle: the load data goes directly to active and pending_valid ends 0.
  - A displayed frame never mixes old and new digits.
- frame_done: registered; asserted for exactly one cycle, in the cycle after wrap.
- Output registers, one cycle latency from (index, prescaler):
  - Dead time (prescaler < BLANK_CYCLES): an = all ones, seg = 7'b1111111, dp = 1.
  - Otherwise an = ~(1 << index); seg and dp come from active-frame digit index.
- Decode (active low, GFEDCBA):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000.
  - HEX_MODE=1: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - HEX_MODE=0: codes 10..15 give 1111111.
- Leading-zero blanking (active lzb = 1):
  - Digit i, i > 0, has seg = 1111111 if its code and every higher-order code are 0.
  - Digit 0 is never LZB-blanked.
  - dp is unaffected by LZB.
- blank_in bit set: seg = 1111111 and dp = 1 for that digit; the anode still scans.
- NUM_DIGITS = 1: index stays 0; wrap occurs on every tick.

Test Plan:
- Reset:
  - Stimulus: hold rst_n = 0, toggle clk; release; NUM_DIGITS=4, CLK_DIV=4, BLANK_CYCLES=1.
  - Response: seg=7F, dp=1, an=4'b1111 throughout reset; after release, an cycles 1110,1101,1011,0111 (each 3 cycles, separated by 1 dark cycle); frame_done pulses every 16 cycles.
- Decode:
  - Stimulus: load digits_in=16'h9A30, HEX_MODE=1.
  - Response: after the next wrap, slots 0..3 show seg 1000000, 0110000, 0001000, 0011000.
  - Same stimulus with HEX_MODE=0: slot 2 shows 1111111.
- Double buffer:
  - Stimulus: load 16'h1234 mid-frame (index 1), then load 16'h5678 before the wrap.
  - Response: the current frame keeps its old data; the next frame shows 5678; 1234 is never displayed.
- Load at wrap:
  - Stimulus: load 16'h4321 in the exact wrap cycle.
  - Response: the next slot 0 shows 1 (1111001); pending_valid = 0 afterwards.
- LZB, blanking and dp:
  - Stimulus: load 16'h0050 with lzb_en=1, dp_in=4'b0010, blank_in=0.
  - Response: digits 3 and 2 show 1111111; digit 1 shows 0010010 with dp=0; digit 0 shows 1000000.
  - Then blank_in=4'b0010: digit 1 shows seg 7F and dp=1.
- Async reset mid-slot:
  - Stimulus: assert rst_n=0 while an=1011.
  - Response: an=1111, seg=7F immediately (before the next edge); after release, scanning restarts at digit 0 with the all-zero frame showing 1000000.

Source files
------------

// File: rtl/seg_display_mux_if.sv
// Display-driver bundle: frame inputs from the datapath (digit codes,
// decimal points, blanking, leading-zero enable, load strobe) and the
// active-low pin outputs (seg, dp, an) plus the end-of-frame pulse.
//   master : datapath side, drives the frame inputs, observes the pins
//   slave  : seg_display_mux side
interface seg_display_mux_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    lzb_en;
  logic                    load;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output digits_in, dp_in, blank_in, lzb_en, load,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  digits_in, dp_in, blank_in, lzb_en, load,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg_display_mux.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// A double-buffered frame is scanned one digit per CLK_DIV-cycle slot; each
// slot opens with BLANK_CYCLES of all-anodes-off dead time to stop ghosting.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset; outputs go dark on assertion
//   bus    - seg_display_mux_if.slave: digits_in/dp_in/blank_in/lzb_en/load
//            in, seg/dp/an (active low) and frame_done out, all registered
module seg_display_mux #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned CLK_DIV      = 100000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned HEX_MODE     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  seg_display_mux_if.slave    bus
);

  localparam int unsigned PS_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DIG_W = 4 * NUM_DIGITS;

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(CLK_DIV - 1);
  localparam logic [PS_W-1:0]  PS_BLANK = PS_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_OFF  = 7'b1111111;

  // Parameter legality, caught at elaboration
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("seg_display_mux: NUM_DIGITS must be 1..8");
  end
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("seg_display_mux: CLK_DIV must be at least 2");
  end
  if (BLANK_CYCLES >= CLK_DIV) begin : g_bad_blank
    $error("seg_display_mux: BLANK_CYCLES must be below CLK_DIV");
  end

  // Scan position
  logic [PS_W-1:0]  prescaler;
  logic [IDX_W-1:0] index;
  logic             tick_c;
  logic             wrap_c;

  // Active (displayed) and pending (next) frames
  logic [DIG_W-1:0]      act_digits;
  logic [NUM_DIGITS-1:0] act_dp;
  logic [NUM_DIGITS-1:0] act_blank;
  logic                  act_lzb;
  logic [DIG_W-1:0]      pend_digits;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [NUM_DIGITS-1:0] pend_blank;
  logic                  pend_lzb;
  logic                  pend_valid;

  // Next output values
  logic [NUM_DIGITS-1:0] lz_c;
  logic [6:0]            seg_c;
  logic                  dp_c;
  logic [NUM_DIGITS-1:0] an_c;
  logic                  dead_c;

  // Active-low GFEDCBA glyph for one digit code
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    s = SEG_OFF;
    case (code)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0011000;
      4'hA: s = (HEX_MODE != 0) ? 7'b0001000 : SEG_OFF;
      4'hB: s = (HEX_MODE != 0) ? 7'b0000011 : SEG_OFF;
      4'hC: s = (HEX_MODE != 0) ? 7'b1000110 : SEG_OFF;
      4'hD: s = (HEX_MODE != 0) ? 7'b0100001 : SEG_OFF;
      4'hE: s = (HEX_MODE != 0) ? 7'b0000110 : SEG_OFF;
      4'hF: s = (HEX_MODE != 0) ? 7'b0001110 : SEG_OFF;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  assign tick_c = (prescaler == PS_LAST);
  assign wrap_c = tick_c && (index == IDX_LAST);

  // Slot timer and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      index     <= '0;
    end else begin
      if (tick_c) begin
        prescaler <= '0;
        index     <= (index == IDX_LAST) ? '0 : index + IDX_W'(1);
      end else begin
        prescaler <= prescaler + PS_W'(1);
      end
    end
  end

  // Double buffer: frames swap only on the last-slot boundary, so a scan
  // never mixes two frames. A load coinciding with the wrap bypasses pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_digits  <= '0;
      act_dp      <= '0;
      act_blank   <= '0;
      act_lzb     <= 1'b0;
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_blank  <= '0;
      pend_lzb    <= 1'b0;
      pend_valid  <= 1'b0;
    end else if (bus.load) begin
      if (wrap_c) begin
        act_digits <= bus.digits_in;
        act_dp     <= bus.dp_in;
        act_blank  <= bus.blank_in;
        act_lzb    <= bus.lzb_en;
        pend_valid <= 1'b0;
      end else begin
        pend_digits <= bus.digits_in;
        pend_dp     <= bus.dp_in;
        pend_blank  <= bus.blank_in;
        pend_lzb    <= bus.lzb_en;
        pend_valid  <= 1'b1;
      end
    end else if (wrap_c && pend_valid) begin
      act_digits <= pend_digits;
      act_dp     <= pend_dp;
      act_blank  <= pend_blank;
      act_lzb    <= pend_lzb;
      pend_valid <= 1'b0;
    end
  end

  // Leading-zero mask: bit i set when digit i and every higher digit are 0.
  // Digit 0 always shows, so its bit is forced clear.
  always_comb begin
    logic run;
    lz_c = '0;
    run  = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      run     = run & (act_digits[4*i +: 4] == 4'd0);
      lz_c[i] = run;
    end
    lz_c[0] = 1'b0;
  end

  assign dead_c = (prescaler < PS_BLANK);

  // Pin values for the current scan position
  always_comb begin
    seg_c = SEG_OFF;
    dp_c  = 1'b1;
    an_c  = '1;
    if (!dead_c) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (index == IDX_W'(i)) begin
          an_c[i] = 1'b0;
          if (!act_blank[i]) begin
            seg_c = (act_lzb && lz_c[i]) ? SEG_OFF : decode(act_digits[4*i +: 4]);
            dp_c  = ~act_dp[i];
          end
        end
      end
    end
  end

  // Registered pins; async reset darkens the display immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.seg        <= SEG_OFF;
      bus.dp         <= 1'b1;
      bus.an         <= '1;
      bus.frame_done <= 1'b0;
    end else begin
      bus.seg        <= seg_c;
      bus.dp         <= dp_c;
      bus.an         <= an_c;
      bus.frame_done <= wrap_c;
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Bench for seg_display_mux: a position-based reference model compared on
// every falling edge, plus directed scenarios with literal glyph checks.
module tb_seg_display_mux;

  localparam int ND    = 4;
  localparam int CD    = 4;
  localparam int BC    = 1;
  localparam int FRAME = ND * CD;

  localparam logic [6:0] DEC [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  bl;
    logic        lzb;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_display_mux_if #(.NUM_DIGITS(ND)) bus ();
  seg_display_mux_if #(.NUM_DIGITS(ND)) bus0 ();

  assign bus0.digits_in = bus.digits_in;
  assign bus0.dp_in     = bus.dp_in;
  assign bus0.blank_in  = bus.blank_in;
  assign bus0.lzb_en    = bus.lzb_en;
  assign bus0.load      = bus.load;

  seg_display_mux #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYCLES(BC), .HEX_MODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  seg_display_mux #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYCLES(BC), .HEX_MODE(0)) dut_dec (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  frame_t     m_act, m_pend;
  bit         m_pv;
  int         cnt = 0;   // clock edges since reset release = scan position
  logic [6:0] e_seg, e_seg0;
  logic       e_dp, e_fd;
  logic [3:0] e_an;

  function automatic logic [6:0] glyph(input frame_t f, input int slot, input bit hex);
    logic [15:0] dd;
    logic [3:0]  code;
    bit          lead;
    dd = f.d;
    if (f.bl[slot]) return 7'h7F;
    lead = 1'b1;
    for (int j = slot; j < ND; j++) if (dd[4*j +: 4] != 4'd0) lead = 1'b0;
    if (f.lzb && slot > 0 && lead) return 7'h7F;
    code = dd[4*slot +: 4];
    if (!hex && code > 4'd9) return 7'h7F;
    return DEC[code];
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int     p, slot, ph;
    bit     wrap;
    frame_t nf;
    if (!rst_n) begin
      cnt    = 0;
      m_act  = '0;
      m_pend = '0;
      m_pv   = 1'b0;
      e_seg  = 7'h7F;
      e_seg0 = 7'h7F;
      e_dp   = 1'b1;
      e_an   = 4'hF;
      e_fd   = 1'b0;
    end else begin
      p    = cnt;
      slot = (p / CD) % ND;
      ph   = p % CD;
      wrap = ((p % FRAME) == FRAME - 1);
      if (ph < BC) begin
        e_seg  = 7'h7F;
        e_seg0 = 7'h7F;
        e_dp   = 1'b1;
        e_an   = 4'hF;
      end else begin
        e_an   = ~(4'(1) << slot);
        e_seg  = glyph(m_act, slot, 1'b1);
        e_seg0 = glyph(m_act, slot, 1'b0);
        e_dp   = m_act.bl[slot] ? 1'b1 : ~m_act.dp[slot];
      end
      e_fd = wrap;
      nf.d   = bus.digits_in;
      nf.dp  = bus.dp_in;
      nf.bl  = bus.blank_in;
      nf.lzb = bus.lzb_en;
      if (bus.load) begin
        if (wrap) begin
          m_act = nf;
          m_pv  = 1'b0;
        end else begin
          m_pend = nf;
          m_pv   = 1'b1;
        end
      end else if (wrap && m_pv) begin
        m_act = m_pend;
        m_pv  = 1'b0;
      end
      cnt++;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_seg", bus.seg, 7'h7F);
      check("rst_dp", bus.dp, 1'b1);
      check("rst_an", bus.an, 4'hF);
      check("rst_fd", bus.frame_done, 1'b0);
    end else if (cnt > 0) begin
      check("seg", bus.seg, e_seg);
      check("dp", bus.dp, e_dp);
      check("an", bus.an, e_an);
      check("frame_done", bus.frame_done, e_fd);
      check("seg_dec", bus0.seg, e_seg0);
    end
  end

  // ---------------- directed helpers ----------------
  // Stop on the falling edge where the given digit is shown mid-slot
  task automatic goto(input int slot);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 3 * FRAME && !hit; k++) begin
      @(negedge clk);
      if (cnt > 0 && ((cnt - 1) % CD) == 2 && (((cnt - 1) / CD) % ND) == slot) hit = 1'b1;
    end
    if (!hit) timeout("goto_slot");
  endtask

  task automatic wait_fd(output int at);
    bit hit;
    hit = 1'b0;
    at  = 0;
    for (int k = 0; k < 3 * FRAME && !hit; k++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin
        hit = 1'b1;
        at  = cnt;
      end
    end
    if (!hit) timeout("wait_frame_done");
  endtask

  task automatic load_frame(input logic [15:0] d, input logic [3:0] dpv,
                            input logic [3:0] bl, input logic lz);
    bus.digits_in = d;
    bus.dp_in     = dpv;
    bus.blank_in  = bl;
    bus.lzb_en    = lz;
    bus.load      = 1'b1;
    @(negedge clk);
    bus.load      = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  t1, t2;
    bit  hit;
    bus.digits_in = '0;
    bus.dp_in     = '0;
    bus.blank_in  = '0;
    bus.lzb_en    = 1'b0;
    bus.load      = 1'b0;
    rst_n         = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;

    // Scan order with the all-zero frame
    goto(0); check("scan_an0", bus.an, 4'b1110); check("zero_glyph", bus.seg, 7'h40);
    goto(1); check("scan_an1", bus.an, 4'b1101);
    goto(2); check("scan_an2", bus.an, 4'b1011);
    goto(3); check("scan_an3", bus.an, 4'b0111);
    wait_fd(t1);
    wait_fd(t2);
    check("fd_period", 32'(t2 - t1), 32'd16);

    // Decode, hex and decimal builds
    load_frame(16'h9A30, 4'b0, 4'b0, 1'b0);
    wait_fd(t1);
    goto(0); check("dec_d0", bus.seg, 7'b1000000);
    goto(1); check("dec_d1", bus.seg, 7'b0110000);
    goto(2); check("dec_hexA", bus.seg, 7'b0001000); check("dec_decA", bus0.seg, 7'b1111111);
    goto(3); check("dec_d3", bus.seg, 7'b0011000);

    // Double buffer: latest load wins, current frame untouched
    goto(1); load_frame(16'h1234, 4'b0, 4'b0, 1'b0);
    goto(2); load_frame(16'h5678, 4'b0, 4'b0, 1'b0);
    goto(3); check("dbuf_old", bus.seg, 7'b0011000);
    wait_fd(t1);
    goto(0); check("dbuf_d0", bus.seg, 7'b0000000);
    goto(1); check("dbuf_d1", bus.seg, 7'b1111000);
    goto(2); check("dbuf_d2", bus.seg, 7'b0000010);
    goto(3); check("dbuf_d3", bus.seg, 7'b0010010);

    // Load in the exact wrap cycle
    hit = 1'b0;
    for (int k = 0; k < 3 * FRAME && !hit; k++) begin
      @(negedge clk);
      if ((cnt % FRAME) == FRAME - 1) hit = 1'b1;
    end
    if (!hit) timeout("wait_wrap");
    bus.digits_in = 16'h4321;
    bus.load      = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    check("wrap_fd", bus.frame_done, 1'b1);
    goto(0); check("wrap_d0", bus.seg, 7'b1111001);
    goto(3); check("wrap_d3", bus.seg, 7'b0011001);
    wait_fd(t1);
    goto(0); check("wrap_keep", bus.seg, 7'b1111001);

    // Leading-zero blanking and decimal point
    load_frame(16'h0050, 4'b0010, 4'b0000, 1'b1);
    wait_fd(t1);
    goto(3); check("lzb_d3", bus.seg, 7'b1111111);
    goto(2); check("lzb_d2", bus.seg, 7'b1111111);
    goto(1); check("lzb_d1", bus.seg, 7'b0010010); check("lzb_dp1", bus.dp, 1'b0);
    goto(0); check("lzb_d0", bus.seg, 7'b1000000); check("lzb_dp0", bus.dp, 1'b1);

    // Per-digit blanking keeps the anode scanning
    load_frame(16'h0050, 4'b0010, 4'b0010, 1'b1);
    wait_fd(t1);
    goto(1);
    check("blank_seg", bus.seg, 7'b1111111);
    check("blank_dp", bus.dp, 1'b1);
    check("blank_an", bus.an, 4'b1101);

    // Async reset mid-slot
    goto(2); check("pre_rst_an", bus.an, 4'b1011);
    #1 rst_n = 1'b0;
    #1;
    check("async_an", bus.an, 4'hF);
    check("async_seg", bus.seg, 7'h7F);
    check("async_dp", bus.dp, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("restart_an", bus.an, 4'b1110);
    check("restart_seg", bus.seg, 7'b1000000);
    wait_fd(t1);
    goto(3); check("restart_d3", bus.seg, 7'b1000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
